pc_delay_line: RTL and testbench

//   Parametrised PC alignment pipeline: delays PC by DEPTH cycles so it lines up with the

---
 rtl/pc_delay_line_if.sv | 25 ++
 rtl/pc_delay_line.sv | 61 ++++++
 tb/tb_pc_delay_line.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pc_delay_line_if.sv
// Handshake bundle between the PC generator (master) and the PC delay line (slave).
interface pc_delay_line_if #(
    parameter int PC_WIDTH = 32,
    parameter int DEPTH    = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                stall_i;
    logic                flush_i;
    logic                valid_i;
    logic [PC_WIDTH-1:0] pc_i;
    logic                valid_o;
    logic [PC_WIDTH-1:0] pc_o;
    logic [CW-1:0]       inflight_o;

    modport master (
        output stall_i, flush_i, valid_i, pc_i,
        input  valid_o, pc_o, inflight_o
    );

    modport slave (
        input  stall_i, flush_i, valid_i, pc_i,
        output valid_o, pc_o, inflight_o
    );
endinterface

// File: rtl/pc_delay_line.sv
// Delays the fetch PC by DEPTH un-stalled cycles so it lines up with the BRAM instruction word.
// Per-stage valid bits, stall holds every stage, flush squashes in-flight and incoming entries.
module pc_delay_line #(
    parameter int                  PC_WIDTH = 32,
    parameter int                  DEPTH    = 2,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input logic              clk,
    input logic              rst_n,
    pc_delay_line_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);

    generate
        if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
            $error("pc_delay_line: DEPTH must be in 1..16");
        end
    endgenerate

    logic [DEPTH-1:0]                vld_pipe;
    logic [DEPTH-1:0][PC_WIDTH-1:0]  pc_pipe;
    logic [CW-1:0]                   inflight_q;

    logic [DEPTH-1:0]                vld_next;
    logic [CW-1:0]                   cnt_next;

    // Valid bits after a shift, and their popcount, so the counter moves in the same edge.
    always_comb begin
        vld_next    = '0;
        vld_next[0] = bus.valid_i;
        for (int k = 1; k < DEPTH; k++) begin
            vld_next[k] = vld_pipe[k-1];
        end
        cnt_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt_next = cnt_next + CW'(vld_next[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush_i) begin
            vld_pipe   <= '0;
            inflight_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                pc_pipe[k] <= RESET_PC;
            end
        end else if (!bus.stall_i) begin
            vld_pipe   <= vld_next;
            inflight_q <= cnt_next;
            // pc is captured even when invalid; valid alone qualifies it.
            pc_pipe[0] <= bus.pc_i;
            for (int k = 1; k < DEPTH; k++) begin
                pc_pipe[k] <= pc_pipe[k-1];
            end
        end
    end

    assign bus.valid_o    = vld_pipe[DEPTH-1];
    assign bus.pc_o       = pc_pipe[DEPTH-1];
    assign bus.inflight_o = inflight_q;
endmodule

// File: tb/tb_pc_delay_line.sv
// Bench for pc_delay_line: DEPTH 2/3/1 instances on shared stimulus, each checked against a
// history-queue reference, plus vector-table and hand-written corner sequences on the DEPTH=2 build.
module tb_pc_delay_line;
    typedef struct packed {
        logic        v;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        flush;
        logic        valid;
        logic [31:0] pc;
        logic        ev;
        logic [31:0] epc;
        int          einf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, valid;
    logic [31:0] pc;
    int          n_chk  = 0;
    int          n_fail = 0;

    int          dep[3];
    logic [31:0] rp[3];
    ent_t        hist[3][$];
    vec_t        tbl[$];

    always #5 clk = ~clk;

    pc_delay_line_if #(.PC_WIDTH(32), .DEPTH(2)) if2 ();
    pc_delay_line_if #(.PC_WIDTH(32), .DEPTH(3)) if3 ();
    pc_delay_line_if #(.PC_WIDTH(32), .DEPTH(1)) if1 ();

    assign if2.stall_i = stall;
    assign if2.flush_i = flush;
    assign if2.valid_i = valid;
    assign if2.pc_i    = pc;
    assign if3.stall_i = stall;
    assign if3.flush_i = flush;
    assign if3.valid_i = valid;
    assign if3.pc_i    = pc;
    assign if1.stall_i = stall;
    assign if1.flush_i = flush;
    assign if1.valid_i = valid;
    assign if1.pc_i    = pc;

    pc_delay_line #(.PC_WIDTH(32), .DEPTH(2), .RESET_PC(32'h0))    d2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    pc_delay_line #(.PC_WIDTH(32), .DEPTH(3), .RESET_PC(32'h1000)) d3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    pc_delay_line #(.PC_WIDTH(32), .DEPTH(1), .RESET_PC(32'hFFFC)) d1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic v, input logic [31:0] p);
        rst_n = r;
        stall = s;
        flush = f;
        valid = v;
        pc    = p;
    endtask

    // Reference: output is whatever entered DEPTH accepted edges ago since the last reset/flush.
    task automatic step();
        logic        av[3];
        logic [31:0] apc[3];
        int          ainf[3];
        logic        ev;
        logic [31:0] epc;
        int          einf;
        ent_t        e;
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (!rst_n || flush) begin
                hist[d].delete();
            end else if (!stall) begin
                e.v  = valid;
                e.pc = pc;
                hist[d].push_front(e);
                if (hist[d].size() > 16) void'(hist[d].pop_back());
            end
        end
        #1;
        av[0] = if2.valid_o; apc[0] = if2.pc_o; ainf[0] = int'(if2.inflight_o);
        av[1] = if3.valid_o; apc[1] = if3.pc_o; ainf[1] = int'(if3.inflight_o);
        av[2] = if1.valid_o; apc[2] = if1.pc_o; ainf[2] = int'(if1.inflight_o);
        for (int d = 0; d < 3; d++) begin
            ev   = 1'b0;
            epc  = rp[d];
            einf = 0;
            if (hist[d].size() >= dep[d]) begin
                ev  = hist[d][dep[d]-1].v;
                epc = hist[d][dep[d]-1].pc;
            end
            for (int i = 0; i < dep[d] && i < hist[d].size(); i++) einf += int'(hist[d][i].v);
            chk($sformatf("model D%0d valid_o", dep[d]), 32'(av[d]), 32'(ev));
            chk($sformatf("model D%0d pc_o", dep[d]), apc[d], epc);
            chk($sformatf("model D%0d inflight_o", dep[d]), ainf[d], einf);
        end
    endtask

    task automatic chk2(input string tag, input logic ev, input logic [31:0] epc, input int einf);
        chk({tag, " valid_o"}, 32'(if2.valid_o), 32'(ev));
        chk({tag, " pc_o"}, if2.pc_o, epc);
        chk({tag, " inflight_o"}, int'(if2.inflight_o), einf);
    endtask

    task automatic add(input logic r, input logic s, input logic f, input logic v, input logic [31:0] p,
                       input logic ev, input logic [31:0] epc, input int einf);
        vec_t t;
        t.rst_n = r; t.stall = s; t.flush = f; t.valid = v; t.pc = p;
        t.ev = ev; t.epc = epc; t.einf = einf;
        tbl.push_back(t);
    endtask

    initial begin
        logic vin[6];
        dep[0] = 2; dep[1] = 3; dep[2] = 1;
        rp[0]  = 32'h0; rp[1] = 32'h1000; rp[2] = 32'hFFFC;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // reset, stream 0,4,8,12
        add(0, 0, 0, 0, 32'h000, 0, 32'h000, 0);
        add(1, 0, 0, 1, 32'h000, 0, 32'h000, 1);
        add(1, 0, 0, 1, 32'h004, 1, 32'h000, 2);
        add(1, 0, 0, 1, 32'h008, 1, 32'h004, 2);
        add(1, 0, 0, 1, 32'h00C, 1, 32'h008, 2);
        add(1, 0, 0, 0, 32'h100, 1, 32'h00C, 1);
        // fill with 0x20,0x24, flush under stall with a valid incoming 0x28
        add(1, 0, 0, 1, 32'h020, 0, 32'h100, 1);
        add(1, 0, 0, 1, 32'h024, 1, 32'h020, 2);
        add(1, 1, 1, 1, 32'h028, 0, 32'h000, 0);
        add(1, 0, 0, 1, 32'h040, 0, 32'h000, 1);
        add(1, 0, 0, 0, 32'h044, 1, 32'h040, 1);
        // reset mid-stream with two valid entries
        add(1, 0, 0, 1, 32'h050, 0, 32'h044, 1);
        add(1, 0, 0, 1, 32'h054, 1, 32'h050, 2);
        add(0, 0, 0, 1, 32'h058, 0, 32'h000, 0);
        add(1, 0, 0, 0, 32'h060, 0, 32'h000, 0);
        add(1, 0, 0, 0, 32'h064, 0, 32'h060, 0);
        add(1, 0, 0, 0, 32'h068, 0, 32'h064, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].stall, tbl[i].flush, tbl[i].valid, tbl[i].pc);
            step();
            chk2($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].einf);
        end

        // stall for 3 cycles after 0x14 enters: output frozen, nothing dropped or duplicated
        drive(1, 0, 1, 0, 32'h0);        step();
        drive(1, 0, 0, 1, 32'h10);       step(); chk2("stall a", 0, 32'h00, 1);
        drive(1, 0, 0, 1, 32'h14);       step(); chk2("stall b", 1, 32'h10, 2);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1, 32'h18);   step(); chk2($sformatf("stall hold%0d", i), 1, 32'h10, 2);
        end
        drive(1, 0, 0, 1, 32'h18);       step(); chk2("stall c", 1, 32'h14, 2);
        drive(1, 0, 0, 0, 32'h1C);       step(); chk2("stall d", 1, 32'h18, 1);
        drive(1, 0, 0, 0, 32'h20);       step(); chk2("stall e", 0, 32'h1C, 0);

        // valid toggling across the DEPTH=1 and DEPTH=3 builds
        vin[0] = 1; vin[1] = 0; vin[2] = 1; vin[3] = 0; vin[4] = 0; vin[5] = 0;
        drive(1, 0, 1, 0, 32'h0);        step();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, vin[i], 32'h200 + 32'(4 * i));
            step();
            chk($sformatf("tog%0d D1 valid_o", i), 32'(if1.valid_o), 32'(vin[i]));
            chk($sformatf("tog%0d D1 pc_o", i), if1.pc_o, 32'h200 + 32'(4 * i));
            chk($sformatf("tog%0d D3 valid_o", i), 32'(if3.valid_o), (i >= 2) ? 32'(vin[i-2]) : 32'h0);
        end

        // random stall/flush/valid/reset against the reference
        for (int n = 0; n < 10000; n++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 99) < 30),
                  ($urandom_range(0, 99) < 4),
                  ($urandom_range(0, 99) < 70),
                  $urandom & 32'hFFFF_FFFC);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
